// File: rtl/domand_arb_pkg.sv
// domand_arb_pkg: shared constants and types for the DOM AND arbiter slice.
//   NSHARES/SHARE_W : share count and width of every masked operand
//   NRAND           : pairwise randomness bytes consumed per operation
//   GADGET_LAT      : register stages inside the DOM AND gadget
//   shares_t/rand_t : packed share and randomness vectors
//   rnd_pair_idx()  : byte index of r_ij inside rand_t
//                     (order r01,r02,r03,r04,r12,...,r34)
package domand_arb_pkg;

  localparam int NSHARES    = 5;
  localparam int SHARE_W    = 8;
  localparam int NRAND      = 10;
  localparam int GADGET_LAT = 2;

  typedef logic [NSHARES*SHARE_W-1:0] shares_t;
  typedef logic [NRAND*SHARE_W-1:0]   rand_t;

  // Row-major upper-triangle index. A diagonal pair has no mask byte, so it
  // returns 0 to keep every part-select base in range.
  function automatic int rnd_pair_idx(input int i, input int j);
    int lo;
    int hi;
    lo = (i < j) ? i : j;
    hi = (i < j) ? j : i;
    if (lo == hi) return 0;
    return lo * NSHARES - (lo * (lo + 1)) / 2 + (hi - lo - 1);
  endfunction

endpackage

// File: rtl/domand_arb_dom_and.sv
// domand_arb_dom_and: 5-share domain-oriented masked AND gadget.
// It has two register stages, so c is valid two clocks after a/b/r are applied.
// Ports:
//   clk   - clock (data path only, so there is no reset)
//   a, b  - masked operands, share k at bits [8k+7:8k]
//   r     - pairwise fresh randomness, rand_t byte order
//   dec_0 - inverts output share 0 (NAND). Tie it low for AND.
//   c     - masked result shares
module domand_arb_dom_and
  import domand_arb_pkg::*;
(
  input  logic    clk,
  input  shares_t a,
  input  shares_t b,
  input  rand_t   r,
  input  logic    dec_0,
  output shares_t c
);

  logic [SHARE_W-1:0] prod_d  [NSHARES][NSHARES];
  logic [SHARE_W-1:0] prod_p0 [NSHARES][NSHARES];
  logic               dec_p0;
  shares_t            c_d;
  shares_t            c_p1;

  // Inner-domain terms stay unmasked. Each cross-domain pair (i,j) and (j,i)
  // shares the mask r_ij, so the masks cancel when all output shares are
  // XORed together.
  always_comb begin
    for (int i = 0; i < NSHARES; i++) begin
      for (int j = 0; j < NSHARES; j++) begin
        if (i == j)
          prod_d[i][j] = a[i*SHARE_W +: SHARE_W] & b[j*SHARE_W +: SHARE_W];
        else
          prod_d[i][j] = (a[i*SHARE_W +: SHARE_W] & b[j*SHARE_W +: SHARE_W])
                       ^ r[rnd_pair_idx(i, j)*SHARE_W +: SHARE_W];
      end
    end
  end

  // ---- stage p0: resharing register ----
  always_ff @(posedge clk) begin
    prod_p0 <= prod_d;
    dec_p0  <= dec_0;
  end

  always_comb begin
    c_d = '0;
    for (int i = 0; i < NSHARES; i++) begin
      for (int j = 0; j < NSHARES; j++) begin
        c_d[i*SHARE_W +: SHARE_W] = c_d[i*SHARE_W +: SHARE_W] ^ prod_p0[i][j];
      end
    end
    c_d[SHARE_W-1:0] = c_d[SHARE_W-1:0] ^ {SHARE_W{dec_p0}};
  end

  // ---- stage p1: output register ----
  always_ff @(posedge clk) begin
    c_p1 <= c_d;
  end

  assign c = c_p1;

endmodule

// File: rtl/domand_arb_fifo.sv
// domand_arb_fifo: result buffer with a registered count.
// Ports:
//   clk, rst - clock, asynchronous active-high reset (pointers and count only)
//   push/din - write one entry. The caller guarantees the buffer has room.
//   pop      - discard the head. Ignored while empty.
//   dout     - head entry, valid while count != 0
//   count    - number of stored entries
module domand_arb_fifo #(
  parameter  int DEPTH = 4,
  parameter  int W     = 41,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count_q;
  logic          pop_ok;

  assign pop_ok = pop && (count_q != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push)
        wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop_ok)
        rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      case ({push, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign count = count_q;

endmodule

// File: rtl/domand_arb.sv
// domand_arb: round-robin arbiter that shares one 5-share DOM AND gadget
// between NREQ requesters and buffers the results in order.
// Ports:
//   clk, rst             - clock, asynchronous active-high reset
//   req_valid/req_ready  - per-requester handshake. At most one ready is high.
//   req_a, req_b         - per-requester operands, 40 bits each
//   rnd_valid/rnd_ready  - fresh randomness handshake. One beat is used per issue.
//   rnd_data             - 80-bit pairwise randomness
//   out_valid/out_ready  - result handshake
//   out_id, out_c        - owner index and result shares (0 while idle)
//   busy                 - any operation is in flight or buffered
// Build option: DOMAND_ARB_ZERO_IDLE_EN drives the gadget inputs to zero on
// idle cycles. Without it, the gadget inputs hold the last issued operands.
module domand_arb
  import domand_arb_pkg::*;
#(
  parameter  int NREQ       = 2,
  parameter  int FIFO_DEPTH = 4,
  localparam int IDW        = $clog2(NREQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NREQ-1:0]               req_valid,
  output logic [NREQ-1:0]               req_ready,
  input  logic [NREQ*NSHARES*SHARE_W-1:0] req_a,
  input  logic [NREQ*NSHARES*SHARE_W-1:0] req_b,
  input  logic                          rnd_valid,
  output logic                          rnd_ready,
  input  logic [NRAND*SHARE_W-1:0]      rnd_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [IDW-1:0]                out_id,
  output logic [NSHARES*SHARE_W-1:0]    out_c,
  output logic                          busy
);

  localparam int SW = NSHARES * SHARE_W;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int UW = CW + 1;
  localparam int EW = IDW + SW;

  logic [IDW-1:0] rr;
  logic [IDW-1:0] gnt;
  logic           any_req;
  int             idx;
  logic           credit_ok;
  logic           issue;
  logic [1:0]     inflight;
  logic [UW-1:0]  used;
  logic           vld_p0;
  logic           vld_p1;
  logic [IDW-1:0] id_p0;
  logic [IDW-1:0] id_p1;
  shares_t        a_live;
  shares_t        b_live;
  shares_t        gad_a;
  shares_t        gad_b;
  rand_t          gad_r;
  shares_t        gad_c;
  logic [EW-1:0]  fifo_dout;
  logic [CW-1:0]  fifo_count;

  // Round-robin search that starts at rr and wraps around.
  always_comb begin
    gnt     = '0;
    any_req = 1'b0;
    idx     = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!any_req && req_valid[idx]) begin
        any_req = 1'b1;
        gnt     = IDW'(idx);
      end
    end
  end

  // Every slot that may later need a FIFO entry is reserved at issue time, so
  // an accepted operation never finds the buffer full.
  assign inflight  = {1'b0, vld_p0} + {1'b0, vld_p1};
  assign used      = UW'(fifo_count) + UW'(inflight);
  assign credit_ok = used < UW'(FIFO_DEPTH);
  assign issue     = !rst && any_req && rnd_valid && credit_ok;

  assign req_ready = issue ? (NREQ'(1) << gnt) : '0;
  assign rnd_ready = issue;

  assign a_live = req_a[int'(gnt)*SW +: SW];
  assign b_live = req_b[int'(gnt)*SW +: SW];

`ifdef DOMAND_ARB_ZERO_IDLE_EN
  assign gad_a = issue ? a_live   : '0;
  assign gad_b = issue ? b_live   : '0;
  assign gad_r = issue ? rnd_data : '0;
`else
  shares_t a_hold;
  shares_t b_hold;
  rand_t   r_hold;

  always_ff @(posedge clk) begin
    if (issue) begin
      a_hold <= a_live;
      b_hold <= b_live;
      r_hold <= rnd_data;
    end
  end

  assign gad_a = issue ? a_live   : a_hold;
  assign gad_b = issue ? b_live   : b_hold;
  assign gad_r = issue ? rnd_data : r_hold;
`endif

  domand_arb_dom_and u_gadget (
    .clk   (clk),
    .a     (gad_a),
    .b     (gad_b),
    .r     (gad_r),
    .dec_0 (1'b0),
    .c     (gad_c)
  );

  // ---- stage p0/p1: valid+id tracking that follows the gadget registers ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr     <= '0;
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      id_p0  <= '0;
      id_p1  <= '0;
    end else begin
      if (issue)
        rr <= (gnt == IDW'(NREQ - 1)) ? '0 : gnt + 1'b1;
      vld_p0 <= issue;
      vld_p1 <= vld_p0;
      id_p0  <= gnt;
      id_p1  <= id_p0;
    end
  end

  domand_arb_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (vld_p1),
    .din   ({id_p1, gad_c}),
    .pop   (out_valid && out_ready),
    .dout  (fifo_dout),
    .count (fifo_count)
  );

  // Outputs are gated so that idle and reset states read as zero.
  assign out_valid = (fifo_count != '0);
  assign out_c     = out_valid ? fifo_dout[SW-1:0] : '0;
  assign out_id    = out_valid ? fifo_dout[EW-1 -: IDW] : '0;
  assign busy      = vld_p0 || vld_p1 || out_valid;

endmodule

// File: tb/tb_domand_arb.sv
module tb_domand_arb;

  localparam int NREQ = 2;
  localparam int FD   = 4;
  localparam int IDW  = 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [NREQ-1:0]  req_valid;
  logic [NREQ-1:0]  req_ready;
  logic [NREQ*40-1:0] req_a;
  logic [NREQ*40-1:0] req_b;
  logic             rnd_valid;
  logic             rnd_ready;
  logic [79:0]      rnd_data;
  logic             out_valid;
  logic             out_ready;
  logic [IDW-1:0]   out_id;
  logic [39:0]      out_c;
  logic             busy;

  always #5 clk = ~clk;

  domand_arb #(.NREQ(NREQ), .FIFO_DEPTH(FD)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rnd_valid (rnd_valid),
    .rnd_ready (rnd_ready),
    .rnd_data  (rnd_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_id    (out_id),
    .out_c     (out_c),
    .busy      (busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  function automatic logic [7:0] xor5(input logic [39:0] s);
    logic [7:0] x;
    x = '0;
    for (int i = 0; i < 5; i++) x = x ^ s[i*8 +: 8];
    return x;
  endfunction

  // Reference model: the operations accepted and not yet consumed, in order.
  // Each one carries its owner, its unmasked result and the first cycle it
  // may be seen.
  typedef struct {
    int         id;
    logic [7:0] x;
    int         rdy;
  } op_t;

  op_t             q[$];
  int              rr_m      = 0;
  int              cyc       = 0;
  int              m_idx;
  logic            exp_issue = 1'b0;
  int              exp_g     = 0;
  logic [NREQ-1:0] exp_rdy   = '0;
  logic            exp_ov    = 1'b0;
  int              exp_id    = 0;
  logic [7:0]      exp_x     = '0;
  logic            exp_busy  = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      rr_m = 0;
    end
    exp_issue = 1'b0;
    exp_g     = 0;
    if (!rst && rnd_valid && q.size() < FD) begin
      for (int k = 0; k < NREQ; k++) begin
        m_idx = (rr_m + k) % NREQ;
        if (!exp_issue && req_valid[m_idx]) begin
          exp_issue = 1'b1;
          exp_g     = m_idx;
        end
      end
    end
    exp_rdy  = exp_issue ? (NREQ'(1) << exp_g) : '0;
    exp_ov   = (q.size() > 0) && (q[0].rdy <= cyc);
    exp_id   = exp_ov ? q[0].id : 0;
    exp_x    = exp_ov ? q[0].x : 8'h00;
    exp_busy = (q.size() != 0);
  end

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      rr_m = 0;
    end else begin
      if (exp_ov && out_ready) void'(q.pop_front());
      if (exp_issue) begin
        q.push_back('{exp_g,
                      xor5(req_a[exp_g*40 +: 40]) & xor5(req_b[exp_g*40 +: 40]),
                      cyc + 3});
        rr_m = (exp_g + 1) % NREQ;
      end
    end
    cyc++;
  end

  task automatic rand_data();
    req_a    = {$urandom, $urandom, 16'($urandom)};
    req_b    = {$urandom, $urandom, 16'($urandom)};
    rnd_data = {16'($urandom), $urandom, $urandom};
  endtask

  task automatic to_sample();
    @(negedge clk);
    #1;
  endtask

  task automatic to_drive();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    to_drive();
    rst = 1'b0;
  endtask

  task automatic idle(input int n);
    req_valid = '0;
    rnd_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < n; i++) to_drive();
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = '1; rnd_valid = 1'b1; out_ready = 1'b1;
    rand_data();
    to_sample();
    n_tests++;
    if ({req_ready, rnd_ready, out_valid, busy} !== '0) begin
      n_fail++;
      $display("FAIL reset_ctrl: req_ready=%b rnd_ready=%b out_valid=%b busy=%b, required all 0",
               req_ready, rnd_ready, out_valid, busy);
    end
    n_tests++;
    if (out_id !== '0 || out_c !== '0) begin
      n_fail++;
      $display("FAIL reset_data: out_id=%0d out_c=%h, required 0 0", out_id, out_c);
    end
    to_drive();
    rst = 1'b0; req_valid = '0; rnd_valid = 1'b0;
    to_drive();
  endtask

  task automatic test_single();
    int         lat;
    logic [7:0] got_x;
    logic [IDW-1:0] got_id;
    lat = -1; got_x = '0; got_id = '0;
    rand_data();
    req_a[39:0] = 40'h00_0000_00FF;
    req_b[39:0] = 40'h00_0000_000F;
    req_valid = 2'b01; rnd_valid = 1'b1; out_ready = 1'b1;
    to_sample();
    n_tests++;
    if (req_ready !== 2'b01 || rnd_ready !== 1'b1 || req_ready !== exp_rdy) begin
      n_fail++;
      $display("FAIL single_issue: req_ready=%b rnd_ready=%b, required 01 1", req_ready, rnd_ready);
    end
    for (int c = 1; c <= 6; c++) begin
      to_drive();
      req_valid = '0; rnd_valid = 1'b0;
      to_sample();
      n_tests++;
      if (out_valid !== exp_ov) begin
        n_fail++;
        $display("FAIL single_ov_c%0d: out_valid=%b, required %b", c, out_valid, exp_ov);
      end
      if (out_valid === 1'b1 && lat < 0) begin
        lat = c; got_x = xor5(out_c); got_id = out_id;
      end
    end
    n_tests++;
    if (lat != 3) begin
      n_fail++;
      $display("FAIL single_latency: got %0d cycles, required 3", lat);
    end
    n_tests++;
    if (got_x !== 8'h0F || got_id !== '0) begin
      n_fail++;
      $display("FAIL single_result: xor=%h id=%0d, required 0f 0", got_x, got_id);
    end
    to_drive();
  endtask

  task automatic test_rr();
    int exp_seq[4];
    int ids[$];
    exp_seq = '{0, 1, 0, 1};
    pulse_rst();
    req_valid = 2'b11; rnd_valid = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      rand_data();
      if (c >= 4) begin req_valid = '0; rnd_valid = 1'b0; end
      to_sample();
      if (c < 4) begin
        n_tests++;
        if (req_ready !== (2'b01 << exp_seq[c]) || req_ready !== exp_rdy) begin
          n_fail++;
          $display("FAIL rr_grant_%0d: req_ready=%b, required %b", c, req_ready, 2'b01 << exp_seq[c]);
        end
      end
      n_tests++;
      if (out_valid !== exp_ov || (exp_ov && (out_id !== IDW'(exp_id) || xor5(out_c) !== exp_x))) begin
        n_fail++;
        $display("FAIL rr_out_%0d: out_valid=%b id=%0d xor=%h, required %b %0d %h",
                 c, out_valid, out_id, xor5(out_c), exp_ov, exp_id, exp_x);
      end
      if (out_valid === 1'b1) ids.push_back(int'(out_id));
      to_drive();
    end
    n_tests++;
    if (ids.size() != 4 || ids[0] != 0 || ids[1] != 1 || ids[2] != 0 || ids[3] != 1) begin
      n_fail++;
      $display("FAIL rr_id_seq: got %0d results, required ids 0,1,0,1", ids.size());
    end
  endtask

  task automatic test_rnd_stall();
    req_valid = 2'b11; rnd_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      rand_data();
      to_sample();
      n_tests++;
      if (req_ready !== '0 || rnd_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_%0d: req_ready=%b rnd_ready=%b, required 00 0", c, req_ready, rnd_ready);
      end
      to_drive();
    end
    rnd_valid = 1'b1;
    rand_data();
    to_sample();
    n_tests++;
    if (rnd_ready !== 1'b1 || req_ready !== exp_rdy || req_ready === '0) begin
      n_fail++;
      $display("FAIL stall_release: req_ready=%b rnd_ready=%b, required %b 1", req_ready, rnd_ready, exp_rdy);
    end
    to_drive();
    idle(6);
  endtask

  task automatic test_backpressure();
    int         issues;
    logic       prev_hold;
    logic [39:0] prev_c;
    logic [IDW-1:0] prev_id;
    issues = 0; prev_hold = 1'b0; prev_c = '0; prev_id = '0;
    pulse_rst();
    req_valid = 2'b11; rnd_valid = 1'b1; out_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      rand_data();
      to_sample();
      if (rnd_ready === 1'b1) issues++;
      n_tests++;
      if (req_ready !== exp_rdy || out_valid !== exp_ov || busy !== exp_busy) begin
        n_fail++;
        $display("FAIL bp_cycle_%0d: req_ready=%b out_valid=%b busy=%b, required %b %b %b",
                 c, req_ready, out_valid, busy, exp_rdy, exp_ov, exp_busy);
      end
      if (prev_hold) begin
        n_tests++;
        if (out_valid !== 1'b1 || out_c !== prev_c || out_id !== prev_id) begin
          n_fail++;
          $display("FAIL bp_stable_%0d: out_c=%h id=%0d, required %h %0d", c, out_c, out_id, prev_c, prev_id);
        end
      end
      prev_hold = out_valid && !out_ready;
      prev_c = out_c; prev_id = out_id;
      to_drive();
    end
    n_tests++;
    if (issues != 4) begin
      n_fail++;
      $display("FAIL bp_issue_count: got %0d issues, required 4", issues);
    end
    out_ready = 1'b1;
    to_sample();
    n_tests++;
    if (req_ready !== '0 || out_valid !== 1'b1 || xor5(out_c) !== exp_x) begin
      n_fail++;
      $display("FAIL bp_pop: req_ready=%b out_valid=%b xor=%h, required 00 1 %h",
               req_ready, out_valid, xor5(out_c), exp_x);
    end
    to_drive();
    out_ready = 1'b0;
    issues = 0;
    for (int c = 0; c < 6; c++) begin
      rand_data();
      to_sample();
      if (rnd_ready === 1'b1) issues++;
      to_drive();
    end
    n_tests++;
    if (issues != 1) begin
      n_fail++;
      $display("FAIL bp_refill: got %0d issues after one pop, required 1", issues);
    end
    req_valid = '0; rnd_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      to_sample();
      n_tests++;
      if (out_valid !== exp_ov || (exp_ov && (out_id !== IDW'(exp_id) || xor5(out_c) !== exp_x))) begin
        n_fail++;
        $display("FAIL bp_drain_%0d: out_valid=%b id=%0d xor=%h, required %b %0d %h",
                 c, out_valid, out_id, xor5(out_c), exp_ov, exp_id, exp_x);
      end
      to_drive();
    end
  endtask

  task automatic test_stream();
    int pops;
    pops = 0;
    rnd_valid = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 106; c++) begin
      rand_data();
      req_valid = (c < 100) ? NREQ'($urandom_range(1, 3)) : '0;
      to_sample();
      if (c < 100) begin
        n_tests++;
        if (rnd_ready !== 1'b1 || req_ready !== exp_rdy) begin
          n_fail++;
          $display("FAIL stream_issue_%0d: req_ready=%b rnd_ready=%b, required %b 1", c, req_ready, rnd_ready, exp_rdy);
        end
      end
      n_tests++;
      if (out_valid !== exp_ov || (exp_ov && (out_id !== IDW'(exp_id) || xor5(out_c) !== exp_x))) begin
        n_fail++;
        $display("FAIL stream_out_%0d: out_valid=%b id=%0d xor=%h, required %b %0d %h",
                 c, out_valid, out_id, xor5(out_c), exp_ov, exp_id, exp_x);
      end
      if (out_valid === 1'b1) pops++;
      to_drive();
    end
    n_tests++;
    if (pops != 100) begin
      n_fail++;
      $display("FAIL stream_count: got %0d results, required 100", pops);
    end
    idle(3);
  endtask

  task automatic test_mid_reset();
    req_valid = 2'b11; rnd_valid = 1'b1; out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      rand_data();
      to_drive();
    end
    req_valid = '0; rnd_valid = 1'b0;
    n_tests++;
    if (out_valid !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_before: out_valid=%b busy=%b, required 1 1", out_valid, busy);
    end
    rst = 1'b1;
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_c !== '0 || out_id !== '0) begin
      n_fail++;
      $display("FAIL midrst_immediate: out_valid=%b busy=%b out_c=%h out_id=%0d, required 0 0 0 0",
               out_valid, busy, out_c, out_id);
    end
    to_drive();
    rst = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      to_sample();
      n_tests++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL midrst_stale_%0d: out_valid=%b busy=%b, required 0 0", c, out_valid, busy);
      end
      to_drive();
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; rnd_valid = 1'b0; out_ready = 1'b0;
    req_a = '0; req_b = '0; rnd_data = '0;
    test_reset();
    test_single();
    test_rr();
    test_rnd_stall();
    test_backpressure();
    test_stream();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/domand_arb.md
DOMAND_ARB -- requirements
Module: domand_arb

Interface
REQ-001 SHALL have parameter NREQ, default 2, number of requesters sharing one 5-share DOM AND gadget (NREQ >= 2).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, result buffer depth (FIFO_DEPTH >= 3).
REQ-003 SHALL have port clk, input, 1 bit, single clock; all state on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit, asynchronous active-high reset.
REQ-005 SHALL have port req_valid, input, NREQ bits, per-requester operand valid.
REQ-006 SHALL have port req_ready, output, NREQ bits, per-requester accept, at most one bit high per cycle.
REQ-007 SHALL have port req_a, input, NREQ*40 bits, per requester 5 shares x 8 bits; share k at bits [8k+7:8k].
REQ-008 SHALL have port req_b, input, NREQ*40 bits, same packing as req_a.
REQ-009 SHALL have port rnd_valid, input, 1 bit, fresh randomness available.
REQ-010 SHALL have port rnd_ready, output, 1 bit, randomness consumed this cycle.
REQ-011 SHALL have port rnd_data, input, 80 bits, byte order r01,r02,r03,r04,r12,r13,r14,r23,r24,r34 from byte 0 upward.
REQ-012 SHALL have port out_valid, output, 1 bit, result available.
REQ-013 SHALL have port out_ready, input, 1 bit, consumer accepts result.
REQ-014 SHALL have port out_id, output, $clog2(NREQ) bits, index of the requester that owns the result.
REQ-015 SHALL have port out_c, output, 40 bits, 5 result shares, same packing as req_a.
REQ-016 SHALL have port busy, output, 1 bit, high while any operation is in flight or buffered.

Function
REQ-017 SHALL issue in a cycle iff any req_valid is high, rnd_valid is high and credit > 0, where credit = FIFO_DEPTH - inflight - occupancy, all from registered state only.
REQ-018 SHALL select the grantee round-robin, starting the search at pointer rr; after a grant to g, rr becomes (g+1) mod NREQ; rr is unchanged on non-issue cycles.
REQ-019 SHALL on issue assert req_ready[g] and rnd_ready in the same cycle; both SHALL be low on non-issue cycles.
REQ-020 SHALL consume exactly one rnd beat per issue, so no randomness is ever reused across operations.
REQ-021 SHALL drive the gadget with req_a[g], req_b[g] and rnd_data on the issue cycle, and drive its dec_0 input to 0.
REQ-022 SHALL track a 2-stage valid+id shift pipeline matching the gadget's 2-register latency, and push {id, c} into the FIFO on the cycle the gadget output is valid.
REQ-023 SHALL have a latency of 3 cycles from the issue cycle to out_valid high, with the FIFO empty and out_ready high.
REQ-024 SHALL assert out_valid whenever the FIFO is non-empty and pop on out_valid & out_ready; out_c and out_id SHALL be stable while out_valid is high and out_ready is low.
REQ-025 SHALL, via the credit rule, never push to a full FIFO; with FIFO_DEPTH=4 and out_ready held high it SHALL sustain one issue per cycle.
REQ-026 SHALL, for a push and pop in the same cycle, leave occupancy unchanged; a push into an empty FIFO SHALL appear on out_valid the next cycle.
REQ-027 SHALL drive busy = (inflight != 0) | (occupancy != 0).

Reset
REQ-028 SHALL, on rst, immediately clear rr, the pipeline valids, the FIFO pointers and occupancy; req_ready, rnd_ready, out_valid and busy SHALL read 0, and out_id and out_c SHALL read 0.
REQ-029 SHALL, on a reset asserted mid-operation, discard in-flight and buffered results; no out_valid pulse SHALL follow deassertion without a new issue.

Configuration
REQ-030 SHALL, with DOMAND_ARB_ZERO_IDLE_EN defined, force all gadget a, b and r inputs to 0 on every non-issue cycle.
REQ-031 SHALL, without DOMAND_ARB_ZERO_IDLE_EN, hold the gadget inputs at the last issued values on non-issue cycles; functional outputs SHALL be identical either way.

Structure
REQ-032 SHALL place in package domand_arb_pkg the constants NSHARES=5, SHARE_W=8, NRAND=10 and GADGET_LAT=2, and the typedefs shares_t (40 bits) and rand_t (80 bits).
REQ-033 SHALL instantiate the team's 5-share DOM AND gadget once, and implement the result buffer as sub-module domand_arb_fifo.

Verification
REQ-034 SHALL cover this scenario: single op; a0=0xFF, all other a shares 0x00, b0=0x0F, all other b shares 0x00, r arbitrary -> out_valid 3 cycles after issue, XOR of the out_c shares = 0x0F, out_id=0.
REQ-035 SHALL cover this scenario: both requesters valid for 4 cycles with rnd_valid=1 -> grants 0,1,0,1 and out_id sequence 0,1,0,1.
REQ-036 SHALL cover this scenario: rnd_valid=0 with req_valid=2'b11 -> no req_ready and no rnd_ready; issue the cycle after rnd_valid rises.
REQ-037 SHALL cover this scenario: out_ready=0 with continuous requests -> exactly 4 issues, then req_ready stays low; one pop then permits exactly one more issue.
REQ-038 SHALL cover this scenario: out_ready=1 with continuous requests -> one issue every cycle, with the XOR of out_c shares equal to (XOR a) & (XOR b) for 100 random ops.
REQ-039 SHALL cover this scenario: rst pulsed with 2 ops in flight and 2 buffered -> out_valid=0 and busy=0 immediately, and no stale result after release.
